// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Data-memory responder for a single-cycle CPU: word RAM plus an
//             MMIO window with a TX stream FIFO and a loadable cycle counter.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready
);

    localparam int                   c_RAM_AW     = $clog2(RAM_WORDS);
    localparam int                   c_FIFO_AW    = $clog2(FIFO_DEPTH);
    localparam logic [15:0]          c_OFF_TXDATA = 16'h0000;
    localparam logic [15:0]          c_OFF_STATUS = 16'h0004;
    localparam logic [15:0]          c_OFF_CYCLE  = 16'h0008;
    localparam logic [c_FIFO_AW:0]   c_FIFO_FULL  = (c_FIFO_AW + 1)'(FIFO_DEPTH);

    logic [31:0]           r_ram  [RAM_WORDS];
    logic [31:0]           r_fifo [FIFO_DEPTH];
    logic [c_FIFO_AW-1:0]  r_wptr;
    logic [c_FIFO_AW-1:0]  r_rptr;
    logic [c_FIFO_AW:0]    r_count;
    logic                  r_ovf;
    logic [31:0]           r_cycle;

    logic                  w_is_mmio;
    logic [15:0]           w_off;
    logic [c_RAM_AW-1:0]   w_ram_idx;
    logic                  w_sel_tx;
    logic                  w_sel_status;
    logic                  w_sel_cycle;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_ovf_set;
    logic                  w_ovf_clr;
    logic [7:0]            w_count8;

    assign w_is_mmio    = (addr >= MMIO_BASE);
    assign w_off        = addr[15:0];
    assign w_ram_idx    = addr[c_RAM_AW+1:2];
    assign w_sel_tx     = w_is_mmio && (w_off == c_OFF_TXDATA);
    assign w_sel_status = w_is_mmio && (w_off == c_OFF_STATUS);
    assign w_sel_cycle  = w_is_mmio && (w_off == c_OFF_CYCLE);

    assign w_full    = (r_count == c_FIFO_FULL);
    assign w_empty   = (r_count == '0);
    assign w_count8  = 8'(r_count);
    assign w_pop     = !w_empty && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push    = memwrite && w_sel_tx && (!w_full || w_pop);
    assign w_ovf_set = memwrite && w_sel_tx && w_full && !w_pop;
    assign w_ovf_clr = memwrite && w_sel_status && writedata[2];

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_fifo[r_rptr];

    always_comb begin
        readdata = '0;
        if (!w_is_mmio) begin
            readdata = r_ram[w_ram_idx];
        end else if (w_sel_status) begin
            readdata = {16'h0000, w_count8, 5'b00000, r_ovf, w_empty, w_full};
        end else if (w_sel_cycle) begin
            readdata = r_cycle;
        end
    end

    // Storage arrays carry no reset; occupancy is governed by r_count alone.
    always_ff @(posedge clk) begin
        if (memwrite && !w_is_mmio) begin
            r_ram[w_ram_idx] <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= writedata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_cycle <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_FIFO_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_FIFO_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_FIFO_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            r_cycle <= (memwrite && w_sel_cycle) ? writedata : r_cycle + 32'd1;
        end
    end

endmodule
`default_nettype wire
